// File: rtl/ball_hit_ctrl.sv
// Per-frame collision and life-cycle controller for one bouncing ball.
// Latches overlaps during a frame, resolves them on startOfFrame, then runs pop/split/respawn/hold.
module ball_hit_ctrl #(
   parameter int POP_FRAMES     = 8,
   parameter int MAX_LEVEL      = 3,
   parameter int RESPAWN_FRAMES = 60,
   parameter int HOLD_FRAMES    = 30,
   parameter int SCORE_BASE     = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        startOfFrame,
   input  logic [10:0] ballTopLeftX,
   input  logic [10:0] ballTopLeftY,
   input  logic        ballDrawReq,
   input  logic        ropeDrawReq,
   input  logic        playerDrawReq,
   output logic        ballVisible,
   output logic        freeze,
   output logic [1:0]  ballLevel,
   output logic        scoreInc,
   output logic [7:0]  scoreValue,
   output logic        splitReq,
   output logic [10:0] splitX,
   output logic [10:0] splitY,
   output logic        lifeLost,
   output logic [2:0]  state_dbg
);

   typedef enum logic [2:0] {
      ST_ALIVE = 3'd0,
      ST_POP   = 3'd1,
      ST_SPLIT = 3'd2,
      ST_GONE  = 3'd3,
      ST_HOLD  = 3'd4
   } state_t;

   localparam logic [7:0] POP_N     = 8'(POP_FRAMES);
   localparam logic [7:0] RESPAWN_N = 8'(RESPAWN_FRAMES);
   localparam logic [7:0] HOLD_N    = 8'(HOLD_FRAMES);
   localparam logic [1:0] MAX_LVL   = 2'(MAX_LEVEL);
   localparam logic [7:0] SCORE_B   = 8'(SCORE_BASE);

   state_t      state, state_n;
   logic [7:0]  cnt, cnt_n;
   logic        rope_hit_f, rope_hit_f_n;
   logic        player_hit_f, player_hit_f_n;
   logic        visible_n;
   logic        freeze_n;
   logic [1:0]  level_n;
   logic        score_inc_n;
   logic [7:0]  score_value_n;
   logic        split_req_n;
   logic [10:0] split_x_n;
   logic [10:0] split_y_n;
   logic        life_lost_n;

   logic        hit_gate;
   logic        rope_ov;
   logic        player_ov;
   logic        rope_eff;
   logic        player_eff;

   assign state_dbg = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_ALIVE;
         cnt          <= 8'd0;
         rope_hit_f   <= 1'b0;
         player_hit_f <= 1'b0;
         ballVisible  <= 1'b1;
         freeze       <= 1'b0;
         ballLevel    <= 2'd0;
         scoreInc     <= 1'b0;
         scoreValue   <= SCORE_B;
         splitReq     <= 1'b0;
         splitX       <= 11'd0;
         splitY       <= 11'd0;
         lifeLost     <= 1'b0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         rope_hit_f   <= rope_hit_f_n;
         player_hit_f <= player_hit_f_n;
         ballVisible  <= visible_n;
         freeze       <= freeze_n;
         ballLevel    <= level_n;
         scoreInc     <= score_inc_n;
         scoreValue   <= score_value_n;
         splitReq     <= split_req_n;
         splitX       <= split_x_n;
         splitY       <= split_y_n;
         lifeLost     <= life_lost_n;
      end
   end

   always_comb begin
      state_n        = state;
      cnt_n          = cnt;
      freeze_n       = freeze;
      level_n        = ballLevel;
      score_inc_n    = 1'b0;
      score_value_n  = scoreValue;
      split_req_n    = 1'b0;
      split_x_n      = splitX;
      split_y_n      = splitY;
      life_lost_n    = 1'b0;
      visible_n      = 1'b1;

      // Only a visible, live ball can be hit; overlaps in any other state are dropped.
      hit_gate   = (state == ST_ALIVE) && ballVisible;
      rope_ov    = hit_gate && ballDrawReq && ropeDrawReq;
      player_ov  = hit_gate && ballDrawReq && playerDrawReq;
      rope_eff   = rope_hit_f || rope_ov;
      player_eff = player_hit_f || player_ov;

      if (startOfFrame) begin
         rope_hit_f_n   = 1'b0;
         player_hit_f_n = 1'b0;
      end else begin
         rope_hit_f_n   = rope_eff;
         player_hit_f_n = player_eff;
      end

      case (state)
         ST_ALIVE: begin
            if (startOfFrame && rope_eff) begin
               state_n       = ST_POP;
               cnt_n         = POP_N;
               score_inc_n   = 1'b1;
               score_value_n = SCORE_B << ballLevel;
               split_x_n     = ballTopLeftX;
               split_y_n     = ballTopLeftY;
            end else if (startOfFrame && player_eff) begin
               state_n     = ST_HOLD;
               cnt_n       = HOLD_N;
               life_lost_n = 1'b1;
               freeze_n    = 1'b1;
            end
         end
         ST_POP: begin
            if (startOfFrame) begin
               cnt_n = cnt - 8'd1;
               if (cnt <= 8'd1) begin
                  state_n = ST_SPLIT;
                  cnt_n   = 8'd0;
               end
            end
         end
         ST_SPLIT: begin
            // Single-cycle decision; a coincident startOfFrame only clears the flags.
            if (ballLevel < MAX_LVL) begin
               split_req_n = 1'b1;
               level_n     = ballLevel + 2'd1;
               state_n     = ST_ALIVE;
            end else begin
               state_n = ST_GONE;
               cnt_n   = RESPAWN_N;
            end
         end
         ST_GONE: begin
            if (startOfFrame) begin
               cnt_n = cnt - 8'd1;
               if (cnt <= 8'd1) begin
                  state_n = ST_ALIVE;
                  cnt_n   = 8'd0;
                  level_n = 2'd0;
               end
            end
         end
         ST_HOLD: begin
            if (startOfFrame) begin
               cnt_n = cnt - 8'd1;
               if (cnt <= 8'd1) begin
                  state_n  = ST_ALIVE;
                  cnt_n    = 8'd0;
                  freeze_n = 1'b0;
               end
            end
         end
         default: begin
            state_n  = ST_ALIVE;
            cnt_n    = 8'd0;
            freeze_n = 1'b0;
         end
      endcase

      // Visibility is registered alongside the state it belongs to.
      case (state_n)
         ST_POP:   visible_n = ~cnt_n[1];
         ST_SPLIT: visible_n = 1'b0;
         ST_GONE:  visible_n = 1'b0;
         default:  visible_n = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_ball_hit_ctrl.sv
// Directed bench for ball_hit_ctrl: frame-level reference model compared every cycle,
// plus hand-computed literal checks at the decision points.
module tb_ball_hit_ctrl;

   localparam int POP_FRAMES     = 8;
   localparam int MAX_LEVEL      = 3;
   localparam int RESPAWN_FRAMES = 60;
   localparam int HOLD_FRAMES    = 30;
   localparam int SCORE_BASE     = 10;
   localparam int FL             = 8;

   localparam int M_ALIVE = 0;
   localparam int M_POP   = 1;
   localparam int M_SPLIT = 2;
   localparam int M_GONE  = 3;
   localparam int M_HOLD  = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        startOfFrame = 1'b0;
   logic [10:0] ballTopLeftX = 11'd0;
   logic [10:0] ballTopLeftY = 11'd0;
   logic        ballDrawReq = 1'b0;
   logic        ropeDrawReq = 1'b0;
   logic        playerDrawReq = 1'b0;
   logic        ballVisible;
   logic        freeze;
   logic [1:0]  ballLevel;
   logic        scoreInc;
   logic [7:0]  scoreValue;
   logic        splitReq;
   logic [10:0] splitX;
   logic [10:0] splitY;
   logic        lifeLost;
   logic [2:0]  state_dbg;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   ball_hit_ctrl #(
      .POP_FRAMES(POP_FRAMES), .MAX_LEVEL(MAX_LEVEL), .RESPAWN_FRAMES(RESPAWN_FRAMES),
      .HOLD_FRAMES(HOLD_FRAMES), .SCORE_BASE(SCORE_BASE)
   ) dut (
      .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
      .ballTopLeftX(ballTopLeftX), .ballTopLeftY(ballTopLeftY),
      .ballDrawReq(ballDrawReq), .ropeDrawReq(ropeDrawReq), .playerDrawReq(playerDrawReq),
      .ballVisible(ballVisible), .freeze(freeze), .ballLevel(ballLevel),
      .scoreInc(scoreInc), .scoreValue(scoreValue), .splitReq(splitReq),
      .splitX(splitX), .splitY(splitY), .lifeLost(lifeLost), .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: frame-level story of the ball
   int          m_mode = M_ALIVE;
   int          m_left = 0;
   int          m_level = 0;
   bit          m_rope = 1'b0;
   bit          m_player = 1'b0;
   logic        e_vis = 1'b1;
   logic        e_freeze = 1'b0;
   logic        e_score_inc = 1'b0;
   logic [7:0]  e_score_val = 8'(SCORE_BASE);
   logic        e_split_req = 1'b0;
   logic [10:0] e_split_x = 11'd0;
   logic [10:0] e_split_y = 11'd0;
   logic        e_life_lost = 1'b0;

   always @(posedge clk or posedge reset) begin : model
      bit r_now, p_now, r_eff, p_eff;
      if (reset) begin
         m_mode = M_ALIVE; m_left = 0; m_level = 0; m_rope = 1'b0; m_player = 1'b0;
         e_vis = 1'b1; e_freeze = 1'b0; e_score_inc = 1'b0; e_score_val = 8'(SCORE_BASE);
         e_split_req = 1'b0; e_split_x = 11'd0; e_split_y = 11'd0; e_life_lost = 1'b0;
      end else begin
         e_score_inc = 1'b0; e_split_req = 1'b0; e_life_lost = 1'b0;
         r_now = (m_mode == M_ALIVE) && ballDrawReq && ropeDrawReq;
         p_now = (m_mode == M_ALIVE) && ballDrawReq && playerDrawReq;
         r_eff = m_rope || r_now;
         p_eff = m_player || p_now;
         m_rope   = startOfFrame ? 1'b0 : r_eff;
         m_player = startOfFrame ? 1'b0 : p_eff;
         if (m_mode == M_ALIVE) begin
            if (startOfFrame && r_eff) begin
               m_mode = M_POP; m_left = POP_FRAMES; e_score_inc = 1'b1;
               e_score_val = 8'((SCORE_BASE * (1 << m_level)) % 256);
               e_split_x = ballTopLeftX; e_split_y = ballTopLeftY;
            end else if (startOfFrame && p_eff) begin
               m_mode = M_HOLD; m_left = HOLD_FRAMES; e_life_lost = 1'b1;
            end
         end else if (m_mode == M_SPLIT) begin
            if (m_level < MAX_LEVEL) begin
               m_level = m_level + 1; e_split_req = 1'b1; m_mode = M_ALIVE;
            end else begin
               m_mode = M_GONE; m_left = RESPAWN_FRAMES;
            end
         end else if (startOfFrame) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
               if (m_mode == M_POP) m_mode = M_SPLIT;
               else begin
                  if (m_mode == M_GONE) m_level = 0;
                  m_mode = M_ALIVE;
               end
            end
         end
         e_freeze = (m_mode == M_HOLD);
         if (m_mode == M_POP) e_vis = ((m_left / 2) % 2) == 0;
         else e_vis = !(m_mode == M_SPLIT || m_mode == M_GONE);
      end
   end

   // scoreboard compare, away from the active edge
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("ballVisible", 32'(ballVisible), 32'(e_vis));
         chk("freeze", 32'(freeze), 32'(e_freeze));
         chk("ballLevel", 32'(ballLevel), 32'(m_level));
         chk("scoreInc", 32'(scoreInc), 32'(e_score_inc));
         if (e_score_inc) chk("scoreValue", 32'(scoreValue), 32'(e_score_val));
         chk("splitReq", 32'(splitReq), 32'(e_split_req));
         chk("splitX", 32'(splitX), 32'(e_split_x));
         chk("splitY", 32'(splitY), 32'(e_split_y));
         chk("lifeLost", 32'(lifeLost), 32'(e_life_lost));
      end
   end

   // driver tasks: inputs change 1 time unit after the active edge
   task automatic drive(input bit sof_b, input bit b, input bit r, input bit p);
      startOfFrame = sof_b; ballDrawReq = b; ropeDrawReq = r; playerDrawReq = p;
      @(posedge clk); #1;
   endtask

   task automatic sof(input int x, input int y, input bit r, input bit p);
      ballTopLeftX = 11'(x); ballTopLeftY = 11'(y);
      drive(1'b1, r | p, r, p);
   endtask

   // pixels 1..5 carry the ball; rope/player cover the first n pixels, plus one
   // stray pixel each outside the ball that must never count
   task automatic body_from(input int first, input int rope_n, input int player_n);
      for (int i = first; i < FL; i++)
         drive(1'b0, i <= 5, (i <= rope_n) || (i == 6), (i <= player_n) || (i == 7));
   endtask

   task automatic frames(input int n, input int rope_n, input int player_n);
      for (int k = 0; k < n; k++) begin
         sof(300 + k, 200 + k, 1'b0, 1'b0);
         body_from(1, rope_n, player_n);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_vis"}, 32'(ballVisible), 1);
      chk({tag, "_freeze"}, 32'(freeze), 0);
      chk({tag, "_level"}, 32'(ballLevel), 0);
      chk({tag, "_scoreInc"}, 32'(scoreInc), 0);
      chk({tag, "_scoreValue"}, 32'(scoreValue), 10);
      chk({tag, "_splitReq"}, 32'(splitReq), 0);
      chk({tag, "_splitX"}, 32'(splitX), 0);
      chk({tag, "_splitY"}, 32'(splitY), 0);
      chk({tag, "_lifeLost"}, 32'(lifeLost), 0);
      chk({tag, "_state"}, 32'(state_dbg), 0);
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      cmp_en = 1'b1;
      drive(1'b0, 1'b1, 1'b1, 1'b1);
      chk_reset_vals("reset");
      reset = 1'b0;

      // rope hit at level 0, 3 overlapping pixels
      sof(10, 20, 1'b0, 1'b0);
      chk("t1_no_event", 32'(scoreInc), 0);
      body_from(1, 3, 0);
      sof(123, 45, 1'b0, 1'b0);
      chk("t1_scoreInc", 32'(scoreInc), 1);
      chk("t1_scoreValue", 32'(scoreValue), 10);
      chk("t1_splitX", 32'(splitX), 123);
      chk("t1_splitY", 32'(splitY), 45);
      chk("t1_lifeLost", 32'(lifeLost), 0);
      chk("t1_vis_pop8", 32'(ballVisible), 1);
      body_from(1, 3, 3);
      sof(500, 501, 1'b0, 1'b0);
      chk("t1_vis_pop7", 32'(ballVisible), 0);
      chk("t1_splitX_held", 32'(splitX), 123);
      body_from(1, 0, 0);
      frames(6, 2, 2);
      sof(600, 601, 1'b0, 1'b0);
      chk("t1_split_vis", 32'(ballVisible), 0);
      chk("t1_split_noreq", 32'(splitReq), 0);
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      chk("t1_splitReq", 32'(splitReq), 1);
      chk("t1_level1", 32'(ballLevel), 1);
      chk("t1_vis_alive", 32'(ballVisible), 1);
      body_from(2, 0, 0);

      // player-only hit: life lost and 30-frame hold
      sof(30, 40, 1'b0, 1'b0);
      chk("t2_no_event", 32'(scoreInc), 0);
      body_from(1, 0, 2);
      sof(31, 41, 1'b0, 1'b0);
      chk("t2_lifeLost", 32'(lifeLost), 1);
      chk("t2_freeze", 32'(freeze), 1);
      chk("t2_noscore", 32'(scoreInc), 0);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("t2_lifeLost_once", 32'(lifeLost), 0);
      body_from(2, 0, 0);
      frames(29, 2, 2);
      chk("t2_freeze_29", 32'(freeze), 1);
      sof(32, 42, 1'b0, 1'b0);
      chk("t2_freeze_off", 32'(freeze), 0);
      chk("t2_vis", 32'(ballVisible), 1);
      body_from(1, 2, 2);

      // rope and player in the same frame: rope wins
      sof(77, 88, 1'b0, 1'b0);
      chk("t3_scoreInc", 32'(scoreInc), 1);
      chk("t3_scoreValue", 32'(scoreValue), 20);
      chk("t3_noLifeLost", 32'(lifeLost), 0);
      chk("t3_nofreeze", 32'(freeze), 0);
      body_from(1, 0, 0);
      frames(8, 0, 0);
      chk("t3_level2", 32'(ballLevel), 2);

      // overlap only on the startOfFrame cycle itself
      sof(5, 6, 1'b0, 1'b0);
      chk("t5_quiet_frame", 32'(scoreInc), 0);
      body_from(1, 0, 0);
      sof(9, 8, 1'b1, 1'b0);
      chk("t5_scoreInc", 32'(scoreInc), 1);
      chk("t5_scoreValue", 32'(scoreValue), 40);
      chk("t5_splitX", 32'(splitX), 9);
      body_from(1, 0, 0);
      frames(8, 0, 0);
      chk("t5_level3", 32'(ballLevel), 3);

      // hit at max level: removal and 60-frame respawn
      sof(1, 2, 1'b0, 1'b0);
      chk("t4_quiet_frame", 32'(scoreInc), 0);
      body_from(1, 1, 0);
      sof(640, 400, 1'b0, 1'b0);
      chk("t4_scoreInc", 32'(scoreInc), 1);
      chk("t4_scoreValue", 32'(scoreValue), 80);
      chk("t4_splitX", 32'(splitX), 640);
      body_from(1, 0, 0);
      frames(7, 0, 0);
      sof(3, 4, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("t4_no_splitReq", 32'(splitReq), 0);
      chk("t4_gone_vis", 32'(ballVisible), 0);
      chk("t4_gone_level", 32'(ballLevel), 3);
      body_from(2, 3, 3);
      frames(59, 3, 3);
      chk("t4_gone_59", 32'(ballVisible), 0);
      sof(7, 7, 1'b0, 1'b0);
      chk("t4_respawn_vis", 32'(ballVisible), 1);
      chk("t4_respawn_level", 32'(ballLevel), 0);
      chk("t4_respawn_noscore", 32'(scoreInc), 0);
      body_from(1, 2, 0);

      // reset pulse in the middle of a pop
      sof(55, 66, 1'b0, 1'b0);
      chk("t6_scoreInc", 32'(scoreInc), 1);
      chk("t6_splitX", 32'(splitX), 55);
      body_from(1, 0, 0);
      sof(56, 67, 1'b0, 1'b0);
      body_from(1, 0, 0);
      reset = 1'b1;
      #1;
      chk_reset_vals("midreset");
      drive(1'b0, 1'b1, 1'b1, 1'b1);
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      reset = 1'b0;
      body_from(1, 0, 0);
      sof(57, 68, 1'b0, 1'b0);
      chk("t6_post_noscore", 32'(scoreInc), 0);
      chk("t6_post_nolife", 32'(lifeLost), 0);
      body_from(1, 0, 0);
      frames(2, 0, 0);

      cmp_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ball_hit_ctrl.md
# ball_hit_ctrl

Per-frame collision and life-cycle controller for one bouncing ball, directly downstream of the ball trajectory and ball drawing stages. It watches the pixel-level draw requests of the ball, the rope (shot) and the player during each frame. At each start of frame it resolves what was hit. It then sequences the ball through pop animation, split/level-up, disappearance and respawn, and emits score, split-request and life-lost events to the game controller.

## Interface
- POP_FRAMES, 8: frames the ball blinks after being hit (1..255)
- MAX_LEVEL, 3: highest size level; a hit at this level removes the ball
- RESPAWN_FRAMES, 60: frames the ball stays gone before relaunch (1..255)
- HOLD_FRAMES, 30: frames motion is frozen after a player hit (1..255)
- SCORE_BASE, 10: points for a level-0 hit
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse per frame
- ballTopLeftX, ballTopLeftY  in  11 each  current ball position from the trajectory stage
- ballDrawReq  in  1  ball sprite covers the current pixel
- ropeDrawReq  in  1  rope covers the current pixel
- playerDrawReq  in  1  player covers the current pixel
- ballVisible  out  1  gate for the ball draw request into the mux
- freeze  out  1  hold ball/player motion (player-hit hold)
- ballLevel  out  2  current size level, 0 = largest
- scoreInc  out  1  one-cycle pulse: add scoreValue
- scoreValue  out  8  SCORE_BASE << ballLevel, sampled with scoreInc
- splitReq  out  1  one-cycle pulse: spawn split balls
- splitX, splitY  out  11 each  ball position latched at hit
- lifeLost  out  1  one-cycle pulse

## Operation
- Frame flags ropeHitF and playerHitF are set when (ballDrawReq & ropeDrawReq) or (ballDrawReq & playerDrawReq) on any cycle. Both are sticky within a frame.
- On startOfFrame, the effective flag is the sticky flag OR the same-cycle overlap. Both flags clear in that cycle.
- Overlaps count only in state ALIVE with ballVisible=1. They are ignored in all other states.
- FSM states: ALIVE, POP, SPLIT, GONE, HOLD.
- ALIVE, at startOfFrame, rope flag set: latch splitX/Y from ballTopLeftX/Y, pulse scoreInc, go to POP, load frame counter = POP_FRAMES.
- ALIVE, at startOfFrame, player flag only: pulse lifeLost, assert freeze, go to HOLD, counter = HOLD_FRAMES.
- Rope and player in the same frame: the rope wins. Only scoreInc fires, and the flow goes to POP.
- POP: ballVisible = ~counter[1], giving a 2-frames-on/2-frames-off blink. Counter decrements per startOfFrame. At 0, go to SPLIT.
- SPLIT (one cycle): if ballLevel < MAX_LEVEL, pulse splitReq, increment ballLevel, go to ALIVE. Otherwise go to GONE with counter = RESPAWN_FRAMES.
- GONE: ballVisible=0. Counter decrements per startOfFrame. At 0, ballLevel=0 and go to ALIVE.
- HOLD: freeze=1, ballVisible=1. Counter decrements per startOfFrame. At 0, freeze=0 and go to ALIVE.
- ballLevel never wraps and saturates at MAX_LEVEL.
- scoreValue is 8 bits; the shift result is truncated to 8 bits.

## Timing
- All outputs are registered. Reset values:
  - state ALIVE, ballVisible 1, freeze 0, ballLevel 0
  - scoreInc, splitReq, lifeLost 0
  - splitX/Y 0, scoreValue SCORE_BASE
  - flags and counter 0
- Decisions occur on the startOfFrame cycle t. State, pulses and latched splitX/Y are visible at t+1.
- Pulses are exactly one cycle wide.
- Counter semantics: a counter loaded with N leaves its state on the N-th subsequent startOfFrame. POP with N=8 therefore spans 8 frames.
- SPLIT lasts exactly one clk cycle, independent of startOfFrame. splitReq is asserted at the SPLIT→ALIVE transition edge, i.e. t+2.
- A startOfFrame arriving while in SPLIT is not lost: the counter logic ignores it and the flags still clear.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous). The first frame after release evaluates only overlaps seen after release.

## Test plan
- Rope/ball overlap for 3 pixels in one frame, level 0 → at SOF+1: scoreInc=1, scoreValue=10, splitX/Y = ball position; blink for 8 frames; splitReq pulse; ballLevel=1.
- Player/ball overlap only → lifeLost for one cycle, freeze=1 for exactly 30 frames, then ALIVE; no scoreInc.
- Rope and player overlap in the same frame → scoreInc only, no lifeLost, state POP.
- Hit at ballLevel=3 → scoreValue=80, no splitReq, ballVisible=0 for 60 frames, then ballLevel=0 and visible.
- Overlap occurring on the exact startOfFrame cycle → counted in the ending frame; a following frame with no overlap produces no event.
- Overlaps during POP/GONE/HOLD → no events. Reset pulse in POP → all outputs at reset values the same cycle.
